// File: rtl/div7_pkg.sv
// Shared types and constants for the divisible-by-7 scan driver and its checker.
package div7_pkg;

  localparam int DIV7_WORD_W  = 32;
  // Cycles from the src handshake edge to the edge where the result is sampled.
  localparam int DIV7_LATENCY = 33;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } div7_state_e;

endpackage

// File: rtl/div7_scan_driver.sv
// Walks base..base+count-1, offers each word to the serial divisible-by-7
// checker, streams out the multiples of 7 and counts them. A per-word timer
// aborts the scan if the checker stops answering.
module div7_scan_driver
  import div7_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DIV7_WORD_W-1:0] base,
  input  logic [CNT_W-1:0]       count,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       hits,
  output logic                   hit_valid,
  output logic [DIV7_WORD_W-1:0] hit_word,
  output logic                   timeout_err,
  output logic [DIV7_WORD_W-1:0] chk_src,
  output logic                   chk_src_valid,
  input  logic                   chk_ready,
  input  logic                   chk_res,
  input  logic                   chk_res_valid
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  div7_state_e            r_state;
  logic [DIV7_WORD_W-1:0] r_cur;
  logic [CNT_W-1:0]       r_remaining;
  logic [CNT_W-1:0]       r_hits;
  logic [TMR_W-1:0]       r_timer;
  logic                   r_hit_valid;
  logic [DIV7_WORD_W-1:0] r_hit_word;
  logic                   r_timeout_err;

  logic w_tmo;
  logic w_last;

  // Timer reaches TIMEOUT on this edge; last word of the range is being captured.
  assign w_tmo  = (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_last = (r_remaining == CNT_W'(1));

  // Scan FSM plus datapath; chk_src holds r_cur so the word is stable through WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cur         <= '0;
      r_remaining   <= '0;
      r_hits        <= '0;
      r_timer       <= '0;
      r_hit_valid   <= 1'b0;
      r_hit_word    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_hit_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_hits        <= '0;
            r_timeout_err <= 1'b0;
            if (count != '0) begin
              r_cur       <= base;
              r_remaining <= count;
              r_timer     <= '0;
              r_state     <= ISSUE;
            end else begin
              r_state     <= DONE;
            end
          end
        end
        ISSUE: begin
          // Results seen here belong to the previous word and are ignored.
          if (chk_ready) begin
            r_timer <= '0;
            r_state <= WAIT;
          end else if (w_tmo) begin
            r_timeout_err <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        WAIT: begin
          if (chk_res_valid) begin
            r_hit_valid <= chk_res;
            r_hit_word  <= r_cur;
            if (chk_res && (r_hits != '1))
              r_hits <= r_hits + CNT_W'(1);
            r_cur       <= r_cur + 32'd1;
            r_remaining <= r_remaining - CNT_W'(1);
            r_timer     <= '0;
            r_state     <= w_last ? DONE : ISSUE;
          end else if (w_tmo) begin
            r_timeout_err <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy          = (r_state == ISSUE) || (r_state == WAIT);
  assign done          = (r_state == DONE);
  assign chk_src_valid = (r_state == ISSUE);
  assign chk_src       = r_cur;
  assign hits          = r_hits;
  assign hit_valid     = r_hit_valid;
  assign hit_word      = r_hit_word;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_div7_scan_driver.sv
// Bench for div7_scan_driver: a behavioural 33-cycle checker model drives the
// checker side; each scan is checked against a list-based reference.
module tb_div7_scan_driver;
  import div7_pkg::*;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 40;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       base = '0;
  logic [CNT_W-1:0]  count = '0;
  logic              busy, done, hit_valid, timeout_err, chk_src_valid;
  logic [CNT_W-1:0]  hits;
  logic [31:0]       hit_word, chk_src;
  logic              chk_ready = 1'b0;
  logic              chk_res = 1'b0;
  logic              chk_res_valid = 1'b0;
  logic              tb_hold = 1'b0;

  always #5 clk = ~clk;

  div7_scan_driver #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
    .busy(busy), .done(done), .hits(hits), .hit_valid(hit_valid),
    .hit_word(hit_word), .timeout_err(timeout_err), .chk_src(chk_src),
    .chk_src_valid(chk_src_valid), .chk_ready(chk_ready), .chk_res(chk_res),
    .chk_res_valid(chk_res_valid)
  );

  // Checker model: result sampled DIV7_LATENCY edges after the handshake,
  // computed from chk_src as it is then; res_valid stays up one stale cycle.
  logic cbusy = 1'b0;
  int   k = 0;
  int   rv_age = 0;
  always @(posedge clk) begin
    if (!rst || tb_hold) begin
      chk_ready <= 1'b0; chk_res_valid <= 1'b0; cbusy <= 1'b0; k <= 0;
    end else begin
      if (chk_res_valid) begin
        rv_age <= rv_age + 1;
        if (rv_age == 1) chk_res_valid <= 1'b0;
      end
      if (cbusy) begin
        k <= k + 1;
        if (k == DIV7_LATENCY - 1) begin
          chk_res_valid <= 1'b1; rv_age <= 0;
          chk_res <= (chk_src % 7 == 0);
          chk_ready <= 1'b1; cbusy <= 1'b0;
        end
      end else if (chk_ready && chk_src_valid) begin
        cbusy <= 1'b1; chk_ready <= 1'b0; k <= 1;
      end else begin
        chk_ready <= 1'b1;
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_hits"}, hits, 0);
    chk({pfx, "_hit_valid"}, hit_valid, 0);
    chk({pfx, "_hit_word"}, hit_word, 0);
    chk({pfx, "_timeout_err"}, timeout_err, 0);
    chk({pfx, "_chk_src"}, chk_src, 0);
    chk({pfx, "_chk_src_valid"}, chk_src_valid, 0);
  endtask

  // One scan. Offsets count posedges after the start-sampling edge S (S = 0).
  task automatic run_scan(input logic [31:0] b, input int c, input int restart_off,
                          input int rst_off, input bit exp_to);
    logic [31:0] exp_hw[$];
    logic [31:0] exp_is[$];
    logic [31:0] got_hw[$];
    logic [31:0] got_is[$];
    logic [31:0] w;
    int done_off = -1;
    bit busy_seen = 0, srcv_seen = 0;
    int budget, exp_off;
    for (int i = 0; i < c; i++) begin
      w = b + 32'(i);
      if (!exp_to) begin
        exp_is.push_back(w);
        if (w % 7 == 0) exp_hw.push_back(w);
      end
    end
    budget = 34 * c + TIMEOUT + 20;
    @(negedge clk);
    start = 1'b1; base = b; count = CNT_W'(c);
    for (int off = 0; off < budget && done_off < 0; off++) begin
      @(posedge clk); @(negedge clk);
      if (off == 0) begin
        start = 1'b0; base = $urandom; count = CNT_W'($urandom);
      end
      if (off == restart_off) begin
        start = 1'b1; base = b + 32'd100; count = CNT_W'(3);
      end else if (off == restart_off + 1) begin
        start = 1'b0;
      end
      if (off == rst_off) begin
        rst = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (busy) busy_seen = 1;
      if (chk_src_valid) srcv_seen = 1;
      if (chk_src_valid && chk_ready) got_is.push_back(chk_src);
      if (hit_valid) got_hw.push_back(hit_word);
      if (done) done_off = off;
    end
    start = 1'b0;
    chk("done_seen", done_off >= 0, 1);
    exp_off = exp_to ? TIMEOUT : 34 * c;
    chk("done_lat", done_off, exp_off);
    chk("hits", hits, exp_hw.size());
    chk("timeout_err", timeout_err, exp_to);
    chk("n_hits", got_hw.size(), exp_hw.size());
    for (int i = 0; i < got_hw.size() && i < exp_hw.size(); i++)
      chk("hit_word", got_hw[i], exp_hw[i]);
    chk("n_issue", got_is.size(), exp_is.size());
    for (int i = 0; i < got_is.size() && i < exp_is.size(); i++)
      chk("issue_word", got_is[i], exp_is[i]);
    if (c == 0) begin
      chk("busy_never", busy_seen, 0);
      chk("srcv_never", srcv_seen, 0);
    end
    @(posedge clk); @(negedge clk);
    chk("done_1cyc", done, 0);
    chk("hits_hold", hits, exp_hw.size());
  endtask

  initial begin
    int c;
    logic [31:0] b;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    run_scan(32'd0, 8, -10, -10, 0);
    run_scan(32'hFFFF_FFFE, 3, -10, -10, 0);
    run_scan(32'd0, 0, -10, -10, 0);

    tb_hold = 1'b1;
    run_scan(32'd14, 1, -10, -10, 1);
    tb_hold = 1'b0;
    repeat (3) @(negedge clk);

    run_scan(32'd7, 5, 60, -10, 0);

    run_scan(32'd0, 8, -10, 50, 0);
    repeat (2) @(negedge clk);
    run_scan(32'd21, 1, -10, -10, 0);
    chk("hit_word_21", hit_word, 32'd21);

    for (int r = 0; r < 6; r++) begin
      b = (r % 2 == 1) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 4)) : 32'($urandom);
      c = $urandom_range(1, 6);
      run_scan(b, c, -10, -10, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
